// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and helpers for the CPU front end.
//   fetch_state_t    : sequencing states of the fetch unit (IDLE, FETCH, EXEC)
//   RESET_PC_DEFAULT : default program counter value after reset
//   AD_* positions   : bit positions of the split 6-bit branch displacement
//   ad_field()       : extracts the 6-bit displacement from an instruction
//   se6_to_16()      : sign-extends a 6-bit two's-complement value to 16 bits
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // The displacement is split across the instruction: the upper three bits
  // share the field position of the A-register select, the lower three bits
  // that of the B-register select.
  localparam int unsigned AD_HI_MSB = 8;
  localparam int unsigned AD_HI_LSB = 6;
  localparam int unsigned AD_LO_MSB = 2;
  localparam int unsigned AD_LO_LSB = 0;

  function automatic logic [5:0] ad_field(input logic [15:0] inst);
    return {inst[AD_HI_MSB:AD_HI_LSB], inst[AD_LO_MSB:AD_LO_LSB]};
  endfunction

  function automatic logic [15:0] se6_to_16(input logic [5:0] value);
    return {{10{value[5]}}, value};
  endfunction

endpackage : cpu_pkg

// File: rtl/next_pc_logic.sv
// -----------------------------------------------------------------------------
// next_pc_logic
// Purely combinational next-program-counter selection.
// Ports:
//   PC      in  16  program counter of the instruction held in INST
//   INST    in  16  current instruction (supplies the branch displacement)
//   PL      in  1   1 = instruction changes control flow
//   JB      in  1   1 = jump to A_BUS, 0 = conditional branch
//   BC      in  1   branch condition select: 0 = on Z, 1 = on N
//   Z, N    in  1   zero / negative flags from the function unit
//   A_BUS   in  16  register-file A read data, used as jump target
//   next_pc out 16  program counter of the following instruction
// All additions wrap modulo 2^16.
// -----------------------------------------------------------------------------
module next_pc_logic
  import cpu_pkg::*;
(
  input  logic [15:0] PC,
  input  logic [15:0] INST,
  input  logic        PL,
  input  logic        JB,
  input  logic        BC,
  input  logic        Z,
  input  logic        N,
  input  logic [15:0] A_BUS,
  output logic [15:0] next_pc
);

  logic [15:0] pc_inc;
  logic [15:0] branch_target;
  logic        branch_cond;

  // Opcode and register-select fields are decoded elsewhere; collecting them
  // here makes it explicit that this block does not depend on them.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{INST[15:9], INST[5:3]};

  // Sequential successor and branch target; the target is relative to the
  // branch's own PC, not PC+1.
  always_comb begin
    pc_inc        = PC + 16'd1;
    branch_target = PC + se6_to_16(ad_field(INST));
  end

  // Branch condition chosen by BC.
  always_comb begin
    branch_cond = 1'b0;
    if (BC) begin
      branch_cond = N;
    end else begin
      branch_cond = Z;
    end
  end

  // Next-PC priority: no control flow, then jump, then conditional branch.
  always_comb begin
    next_pc = pc_inc;
    if (!PL) begin
      next_pc = pc_inc;
    end else if (JB) begin
      next_pc = A_BUS;
    end else if (branch_cond) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_inc;
    end
  end

endmodule : next_pc_logic

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch / program-counter stage. Sequences IDLE -> FETCH -> EXEC,
// fetches 16-bit instructions over a req/ack handshake, holds the instruction
// register for the decoder and advances the PC when the instruction commits.
// Ports:
//   clk         in  1   rising-edge clock
//   rst_n       in  1   synchronous active-low reset
//   imem_req    out 1   instruction-memory read request (high during FETCH)
//   imem_addr   out 16  read address, always equal to PC
//   imem_ack    in  1   read data valid this cycle (honoured in FETCH only)
//   imem_rdata  in  16  instruction word
//   INST        out 16  instruction register, to the decoder
//   PL, JB, BC  in  1   decoder controls for the instruction in INST
//   Z, N        in  1   flags from the datapath function unit
//   A_BUS       in  16  register-file A read data (jump target)
//   exec_stall  in  1   datapath not ready; holds EXEC
//   exec_en     out 1   one-cycle commit strobe for the datapath
//   PC          out 16  current program counter
// -----------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] INST,
  input  logic        PL,
  input  logic        JB,
  input  logic        BC,
  input  logic        Z,
  input  logic        N,
  input  logic [15:0] A_BUS,
  input  logic        exec_stall,
  output logic        exec_en,
  output logic [15:0] PC
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  inst_q, inst_d;
  logic         imem_req_q, imem_req_d;
  logic [15:0]  next_pc;

  next_pc_logic u_next_pc_logic (
    .PC      (pc_q),
    .INST    (inst_q),
    .PL      (PL),
    .JB      (JB),
    .BC      (BC),
    .Z       (Z),
    .N       (N),
    .A_BUS   (A_BUS),
    .next_pc (next_pc)
  );

  // Next-state, register updates and commit strobe. imem_req is computed for
  // the following cycle so that it is a flop output that is high exactly
  // while the state register holds FETCH.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    imem_req_d = 1'b0;
    exec_en    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          inst_d     = imem_rdata;
          state_d    = EXEC;
          imem_req_d = 1'b0;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      EXEC: begin
        // Flags and A_BUS only matter in this commit cycle; while stalled
        // nothing downstream of next_pc is captured.
        exec_en = ~exec_stall;
        if (!exec_stall) begin
          pc_d       = next_pc;
          state_d    = FETCH;
          imem_req_d = 1'b1;
        end else begin
          imem_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // State, PC, instruction and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= 16'h0000;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      imem_req_q <= imem_req_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign INST      = inst_q;

endmodule : fetch_unit
